// File: rtl/fifo_pkg.sv
// Shared async-FIFO helpers: Gray/binary pointer conversion used by both
// the read and write ports.
package fifo_pkg;

   // Conversions run at a fixed maximum width; zero-extending a narrower
   // pointer does not change its Gray or binary value.
   localparam int PTR_MAX_W = 32;
   typedef logic [PTR_MAX_W-1:0] ptr_t;

   // Depth of the read-side output buffer.
   localparam int OBUF_DEPTH = 2;

   function automatic ptr_t bin2gray(input ptr_t b);
      return b ^ (b >> 1);
   endfunction

   function automatic ptr_t gray2bin(input ptr_t g);
      ptr_t b;
      b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
      for (int i = PTR_MAX_W-2; i >= 0; i--)
         b[i] = b[i+1] ^ g[i];
      return b;
   endfunction

   // Gray value the write pointer takes when the FIFO is full relative to
   // rgray: the top two bits of a pw-bit pointer are inverted.
   function automatic ptr_t gray_full_match(input ptr_t rgray, input int unsigned pw);
      return rgray ^ (ptr_t'(3) << (pw - 2));
   endfunction

endpackage

// File: rtl/fifo_sync_2ff.sv
// Two-flop synchronizer for a Gray-coded pointer crossing into this clock domain.
module fifo_sync_2ff #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta <= '0;
         q    <= '0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/fifo_read_port.sv
// Read side of an async FIFO: Gray pointer handling, empty/count status, and
// a 2-entry output buffer that hides the RAM read latency behind a ready/valid port.
module fifo_read_port
   import fifo_pkg::*;
#(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  rclk,
   input  logic                  rrst,
   input  logic [ADDR_WIDTH:0]   rwptr_gray,
   output logic [ADDR_WIDTH:0]   rptr,
   output logic [ADDR_WIDTH-1:0] raddr,
   output logic                  ren,
   input  logic [DATA_WIDTH-1:0] rdata_mem,
   output logic                  rempty,
   output logic [ADDR_WIDTH:0]   rcount,
   output logic                  dout_valid,
   input  logic                  dout_ready,
   output logic [DATA_WIDTH-1:0] dout
);

   localparam int PW = ADDR_WIDTH + 1;

   logic [PW-1:0] rq2_wptr;
   logic [PW-1:0] rbin;
   logic [PW-1:0] n_rbin;
   logic [PW-1:0] n_rgray;
   logic [1:0]    bcnt;
   logic [1:0]    n_bcnt;
   logic [2:0]    occ;
   logic          f;
   logic          pop;
   logic          wr_idx;
   logic [OBUF_DEPTH-1:0][DATA_WIDTH-1:0] obuf;

   fifo_sync_2ff #(.WIDTH(PW)) u_wptr_sync (
      .clk (rclk),
      .rst (rrst),
      .d   (rwptr_gray),
      .q   (rq2_wptr)
   );

   assign pop = dout_valid & dout_ready;

   // Words held plus the word arriving from RAM, after this cycle's pop.
   // Only issue a read when that still leaves a free buffer slot.
   assign occ    = {1'b0, bcnt} + {2'b0, f} - {2'b0, pop};
   assign n_bcnt = occ[1:0];
   assign ren    = !rrst & !rempty & (occ < 3'd2);

   assign n_rbin  = rbin + PW'(ren);
   assign n_rgray = PW'(bin2gray(ptr_t'(n_rbin)));
   assign raddr   = rbin[ADDR_WIDTH-1:0];
   assign rcount  = PW'(gray2bin(ptr_t'(rq2_wptr))) - rbin;

   always_ff @(posedge rclk) begin
      if (rrst) begin
         rbin   <= '0;
         rptr   <= '0;
         rempty <= 1'b1;
         bcnt   <= 2'd0;
         f      <= 1'b0;
      end else begin
         rbin   <= n_rbin;
         rptr   <= n_rgray;
         rempty <= (n_rgray == rq2_wptr);
         bcnt   <= n_bcnt;
         f      <= ren;
      end
   end

   // Tail slot for the arriving word, taken after any pop has shifted the head.
   assign wr_idx = (bcnt == 2'd2) | ((bcnt == 2'd1) & !pop);

   always_ff @(posedge rclk) begin
      if (pop)
         obuf[0] <= obuf[1];
      if (f)
         obuf[wr_idx] <= rdata_mem;
   end

   assign dout_valid = (bcnt != 2'd0);
   assign dout       = obuf[0];

endmodule

// File: tb/tb_fifo_read_port.sv
// Directed bench for fifo_read_port: the bench plays the write side and RAM
// and scoreboards every word that leaves the output port.
module tb_fifo_read_port;

   localparam int AW = 4;
   localparam int DW = 32;
   localparam int PW = AW + 1;

   logic          rclk = 1'b0;
   logic          rrst = 1'b1;
   logic [PW-1:0] rwptr_gray = '0;
   logic [PW-1:0] rptr;
   logic [AW-1:0] raddr;
   logic          ren;
   logic [DW-1:0] rdata_mem = '0;
   logic          rempty;
   logic [PW-1:0] rcount;
   logic          dout_valid;
   logic          dout_ready = 1'b0;
   logic [DW-1:0] dout;

   int n_vec  = 0;
   int n_miss = 0;

   logic [DW-1:0] mem [0:(1<<AW)-1];
   logic [DW-1:0] exp_q [$];
   logic [AW-1:0] raddr_log [$];
   logic [PW-1:0] rptr_log [$];
   int  wbin    = 0;
   int  seq     = 0;
   int  ren_cnt = 0;
   int  pop_cnt = 0;
   bit  log_en  = 1'b0;

   fifo_read_port #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .rclk       (rclk),
      .rrst       (rrst),
      .rwptr_gray (rwptr_gray),
      .rptr       (rptr),
      .raddr      (raddr),
      .ren        (ren),
      .rdata_mem  (rdata_mem),
      .rempty     (rempty),
      .rcount     (rcount),
      .dout_valid (dout_valid),
      .dout_ready (dout_ready),
      .dout       (dout)
   );

   always #5 rclk = ~rclk;

   // RAM with one cycle of read latency.
   always @(posedge rclk)
      if (ren) rdata_mem <= mem[raddr];

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h want %0h", tag, act, exp);
      end
   endtask

   function automatic logic [PW-1:0] to_gray(input int b);
      logic [PW-1:0] x;
      x = PW'(b);
      return x ^ (x >> 1);
   endfunction

   always @(negedge rclk) begin
      if (!rrst) begin
         if (ren) begin
            ren_cnt++;
            chk("ren_while_empty", rempty, 0);
            if (log_en) raddr_log.push_back(raddr);
         end
         if (log_en) rptr_log.push_back(rptr);
         if (dout_valid && dout_ready) begin
            pop_cnt++;
            if (exp_q.size() == 0) chk("spurious_pop", 1, 0);
            else                   chk("pop_data", dout, exp_q.pop_front());
         end
      end
   end

   task automatic tick();
      @(posedge rclk);
      #1;
   endtask

   task automatic do_reset(input int n);
      rrst       = 1'b1;
      dout_ready = 1'b0;
      wbin       = 0;
      rwptr_gray = '0;
      exp_q.delete();
      repeat (n) tick();
      rrst = 1'b0;
   endtask

   task automatic push_word(input logic [DW-1:0] w);
      mem[wbin % (1<<AW)] = w;
      exp_q.push_back(w);
      wbin++;
      rwptr_gray = to_gray(wbin);
   endtask

   task automatic push(input int n);
      for (int i = 0; i < n; i++) begin
         push_word({16'hC0DE, 16'(seq)});
         seq++;
      end
   endtask

   task automatic drain(input int maxc);
      bit done = 1'b0;
      dout_ready = 1'b1;
      repeat (4) tick();
      for (int i = 0; i < maxc && !done; i++) begin
         if (rempty && !dout_valid && !dut.f) done = 1'b1;
         else tick();
      end
      if (!done) chk("drain_timeout", 0, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit found;
      int p0;

      // Reset state and first cycle after reset
      do_reset(2);
      chk("rst_rempty", rempty, 1);
      chk("rst_rptr", rptr, 0);
      chk("rst_dout_valid", dout_valid, 0);
      chk("rst_rcount", rcount, 0);
      chk("post_rst_ren", ren, 0);

      // Single word: pointer changes just after edge 0
      dout_ready = 1'b1;
      push_word(32'hA5A5_0001);
      tick(); tick();
      chk("e2_rempty", rempty, 1);
      tick();
      chk("e3_rempty", rempty, 0);
      chk("c3_ren", ren, 1);
      chk("e3_rcount", rcount, 1);
      tick();
      chk("e4_rptr", rptr, 5'b00001);
      chk("e4_rempty", rempty, 1);
      chk("e4_ren", ren, 0);
      found = 1'b0;
      for (int i = 0; i < 4 && !found; i++) begin
         if (dout_valid) found = 1'b1;
         else tick();
      end
      chk("single_valid", found, 1);
      chk("single_dout", dout, 32'hA5A5_0001);
      tick();
      chk("single_popped", dout_valid, 0);

      // Full burst of 16 words, one beat per cycle
      do_reset(2);
      dout_ready = 1'b1;
      push(16);
      chk("burst_wptr", rwptr_gray, 5'b11000);
      p0 = pop_cnt;
      found = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
         if (dout_valid) found = 1'b1;
         else tick();
      end
      chk("burst_start", found, 1);
      for (int i = 0; i < 16; i++) begin
         chk("burst_beat", dout_valid, 1);
         tick();
      end
      chk("burst_end_valid", dout_valid, 0);
      chk("burst_pops", pop_cnt - p0, 16);
      chk("burst_rptr", rptr, 5'b11000);
      chk("burst_rempty", rempty, 1);
      chk("burst_rcount", rcount, 0);

      // Wrap: advance rbin to 30, then read 4 words across the wrap
      push(14);
      drain(40);
      chk("pre_wrap_rptr", rptr, 5'b10001);
      raddr_log.delete();
      rptr_log.delete();
      log_en = 1'b1;
      push(4);
      tick(); tick();
      chk("wrap_rcount_4", rcount, 4);
      drain(20);
      log_en = 1'b0;
      chk("wrap_nreads", raddr_log.size(), 4);
      if (raddr_log.size() == 4) begin
         chk("wrap_raddr0", raddr_log[0], 14);
         chk("wrap_raddr1", raddr_log[1], 15);
         chk("wrap_raddr2", raddr_log[2], 0);
         chk("wrap_raddr3", raddr_log[3], 1);
      end
      found = 1'b0;
      for (int i = 0; i + 1 < rptr_log.size(); i++)
         if (rptr_log[i] == 5'b10000 && rptr_log[i+1] == 5'b00000) found = 1'b1;
      chk("wrap_rptr_msb", found, 1);
      chk("wrap_rptr_end", rptr, 5'b00011);
      chk("wrap_rcount_0", rcount, 0);
      chk("wrap_rempty", rempty, 1);
      chk("wrap_sb_empty", exp_q.size(), 0);

      // Backpressure: 8 words with the consumer stalled
      do_reset(2);
      dout_ready = 1'b0;
      push(8);
      ren_cnt = 0;
      repeat (10) tick();
      chk("bp_ren_count", ren_cnt, 2);
      chk("bp_bcnt", dut.bcnt, 2);
      chk("bp_rcount", rcount, 6);
      chk("bp_valid", dout_valid, 1);
      chk("bp_dout_word0", dout, exp_q[0]);
      tick();
      chk("bp_dout_hold", dout, exp_q[0]);
      p0 = pop_cnt;
      drain(30);
      chk("bp_delivered", pop_cnt - p0, 8);
      chk("bp_sb_empty", exp_q.size(), 0);

      // Reset while a word is buffered and another is in flight
      do_reset(2);
      dout_ready = 1'b1;
      push(8);
      found = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
         if (dout_valid && dut.f) found = 1'b1;
         else tick();
      end
      chk("mid_rst_setup", found, 1);
      rrst = 1'b1;
      exp_q.delete();
      tick();
      chk("mid_rst_valid", dout_valid, 0);
      chk("mid_rst_rempty", rempty, 1);
      chk("mid_rst_rptr", rptr, 0);
      chk("mid_rst_bcnt", dut.bcnt, 0);
      chk("mid_rst_ren", ren, 0);
      rwptr_gray = '0;
      wbin = 0;
      tick();
      rrst = 1'b0;
      tick();
      chk("mid_rst_after_valid", dout_valid, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
